// File: rtl/lsu.sv
// lsu - load/store unit sitting between execute and memory in the tiny5 core.
//
// Takes one request at a time (effective address, store data, store flag,
// RV32I funct3), performs a single word-aligned bus transaction with byte-lane
// steering and write-mask generation, and returns the extended load data (or
// a misalignment / bus-timeout fault) through a valid/ready response.
//
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   req_*                  request handshake and payload (address, wdata, store, funct3)
//   mem_*                  data-memory bus (word address, lane data, byte mask, we, ready, rdata)
//   resp_*                 response handshake and payload (rdata, misaligned, buserr)
//
// Parameter TIMEOUT_CYCLES: BUS cycles without mem_ready_i before a bus error;
// 0 waits forever.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_misaligned_o,
  output logic        resp_buserr_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] count_reg, count_next;

  logic [29:0] waddr_reg;
  logic [1:0]  offset_reg;
  logic [2:0]  funct3_reg;
  logic        store_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wmask_reg;
  logic [31:0] rdata_reg;
  logic        misaligned_reg;
  logic        buserr_reg;

  // Request decode. funct3[1:0] gives the size; 011/110/111 fall through to word.
  logic        req_is_byte, req_is_half, req_is_word, req_misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mask;

  always_comb begin
    req_is_byte = (req_funct3_i[1:0] == 2'b00);
    req_is_half = (req_funct3_i[1:0] == 2'b01);
    req_is_word = !req_is_byte && !req_is_half;
    req_misaligned = (req_is_half && req_addr_i[0]) ||
                     (req_is_word && (req_addr_i[1:0] != 2'b00));
    lane_wdata = req_wdata_i;
    lane_mask  = 4'b1111;
    if (req_is_byte) begin
      lane_wdata = {4{req_wdata_i[7:0]}};
      lane_mask  = 4'b0001 << req_addr_i[1:0];
    end else if (req_is_half) begin
      lane_wdata = {2{req_wdata_i[15:0]}};
      lane_mask  = 4'b0011 << req_addr_i[1:0];
    end
  end

  // Load extraction from the returned word, using the registered offset/size.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  always_comb begin
    load_byte = mem_rdata_i[8*offset_reg +: 8];
    load_half = offset_reg[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data = mem_rdata_i;
    if (funct3_reg[1:0] == 2'b00)
      load_data = funct3_reg[2] ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
    else if (funct3_reg[1:0] == 2'b01)
      load_data = funct3_reg[2] ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
  end

  // The timeout fires on the BUS cycle whose increment would reach the limit.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_reg + 32'd1 >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i)
          state_next = req_misaligned ? RESP : BUS;
      end
      BUS: begin
        if (mem_ready_i) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = RESP;
          count_next = count_reg + 32'd1;
        end else begin
          count_next = count_reg + 32'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_next = IDLE;
          count_next = 32'd0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      waddr_reg      <= 30'd0;
      offset_reg     <= 2'd0;
      funct3_reg     <= 3'd0;
      store_reg      <= 1'b0;
      wdata_reg      <= 32'd0;
      wmask_reg      <= 4'd0;
      rdata_reg      <= 32'd0;
      misaligned_reg <= 1'b0;
      buserr_reg     <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid_i) begin
        waddr_reg      <= req_addr_i[31:2];
        offset_reg     <= req_addr_i[1:0];
        funct3_reg     <= req_funct3_i;
        store_reg      <= req_store_i;
        wdata_reg      <= lane_wdata;
        wmask_reg      <= req_store_i ? lane_mask : 4'b0000;
        rdata_reg      <= 32'd0;
        misaligned_reg <= req_misaligned;
        buserr_reg     <= 1'b0;
      end else if (state_reg == BUS) begin
        if (mem_ready_i) begin
          if (!store_reg)
            rdata_reg <= load_data;
        end else if (timeout_hit) begin
          buserr_reg <= 1'b1;
        end
      end
    end
  end

  // Bus and response payloads are zero whenever their valid is low.
  logic in_bus, in_resp;
  assign in_bus  = (state_reg == BUS);
  assign in_resp = (state_reg == RESP);

  assign req_ready_o       = (state_reg == IDLE);
  assign mem_valid_o       = in_bus;
  assign mem_addr_o        = in_bus ? {waddr_reg, 2'b00} : 32'd0;
  assign mem_wdata_o       = in_bus ? wdata_reg : 32'd0;
  assign mem_wmask_o       = in_bus ? wmask_reg : 4'd0;
  assign mem_we_o          = in_bus && store_reg;
  assign resp_valid_o      = in_resp;
  assign resp_rdata_o      = in_resp ? rdata_reg : 32'd0;
  assign resp_misaligned_o = in_resp && misaligned_reg;
  assign resp_buserr_o     = in_resp && buserr_reg;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_mis;
  logic        resp_berr;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_store_i(req_store), .req_funct3_i(req_funct3),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask), .mem_we_o(mem_we),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_misaligned_o(resp_mis),
    .resp_buserr_o(resp_berr)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] mrdata;
    int          delay;   // BUS cycles without mem_ready before ready (99 = never)
    int          hold;    // cycles resp_ready is withheld
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic        e_we;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        e_berr;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic store, input logic [2:0] f3, input logic [31:0] mrdata,
                              input int delay, input int hold, input logic [31:0] e_maddr,
                              input logic [31:0] e_wdata, input logic [3:0] e_mask, input logic e_we,
                              input logic [31:0] e_rdata, input logic e_mis, input logic e_berr,
                              input int e_lat);
    vec_t v;
    v.name = name; v.addr = addr; v.wdata = wdata; v.store = store; v.f3 = f3;
    v.mrdata = mrdata; v.delay = delay; v.hold = hold; v.e_maddr = e_maddr;
    v.e_wdata = e_wdata; v.e_mask = e_mask; v.e_we = e_we; v.e_rdata = e_rdata;
    v.e_mis = e_mis; v.e_berr = e_berr; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   bus_n;
    bit   seen_bus;
    bit   done;
    exp_t e;
    e = '{32'd0, 1'b0, 1'b0};
    seen_bus = 0;
    done = 0;
    @(negedge clk);
    chk({v.name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata;
    req_store = v.store; req_funct3 = v.f3;
    sbq.push_back('{v.e_rdata, v.e_mis, v.e_berr});
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_store = 1'b0; req_funct3 = 3'd0;
    cyc = 1;
    bus_n = 0;
    while (!done && cyc <= 40) begin
      mem_ready = 1'b0;
      if (mem_valid) begin
        seen_bus = 1;
        chk({v.name, " mem_addr"}, mem_addr, v.e_maddr);
        chk({v.name, " mem_wdata"}, mem_wdata, v.e_wdata);
        chk({v.name, " mem_wmask"}, {28'd0, mem_wmask}, {28'd0, v.e_mask});
        chk({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.e_we});
        chk({v.name, " req_ready bus"}, {31'd0, req_ready}, 32'd0);
        if (bus_n == v.delay) begin
          mem_ready = 1'b1;
          mem_rdata = v.mrdata;
        end
        bus_n++;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL %s: response with empty scoreboard", v.name);
        end else begin
          e = sbq.pop_front();
        end
        chk({v.name, " latency"}, cyc, v.e_lat);
        chk({v.name, " resp_rdata"}, resp_rdata, e.rdata);
        chk({v.name, " resp_mis"}, {31'd0, resp_mis}, {31'd0, e.mis});
        chk({v.name, " resp_berr"}, {31'd0, resp_berr}, {31'd0, e.berr});
        for (int h = 0; h < v.hold; h++) begin
          @(posedge clk); #1;
          chk({v.name, " hold resp_valid"}, {31'd0, resp_valid}, 32'd1);
          chk({v.name, " hold resp_rdata"}, resp_rdata, e.rdata);
          chk({v.name, " hold resp_berr"}, {31'd0, resp_berr}, {31'd0, e.berr});
          chk({v.name, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({v.name, " resp_valid after"}, {31'd0, resp_valid}, 32'd0);
        chk({v.name, " req_ready after"}, {31'd0, req_ready}, 32'd1);
        done = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no response within cycle budget", v.name);
    end
    chk({v.name, " bus seen"}, {31'd0, seen_bus}, {31'd0, !v.e_mis});
    $display("txn %s addr=%h f3=%0d store=%0d rdata=%h mis=%0d berr=%0d", v.name, v.addr, v.f3,
             v.store, e.rdata, e.mis, e.berr);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_store = 1'b0; req_funct3 = 3'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0; resp_ready = 1'b0;

    //       name    addr          wdata         st f3    mrdata        dly hld maddr         wdata         mask     we rdata         mis berr lat
    vecs.push_back(mk("LB",    32'h0000_1003, 32'h0,        0, 3'b000, 32'h80FF_1234, 0,  0, 32'h0000_1000, 32'h0,        4'b0000, 0, 32'hFFFF_FF80, 0, 0, 2));
    vecs.push_back(mk("LHU",   32'h0000_2002, 32'h0,        0, 3'b101, 32'hBEEF_0000, 0,  0, 32'h0000_2000, 32'h0,        4'b0000, 0, 32'h0000_BEEF, 0, 0, 2));
    vecs.push_back(mk("LH",    32'h0000_2002, 32'h0,        0, 3'b001, 32'hBEEF_0000, 0,  0, 32'h0000_2000, 32'h0,        4'b0000, 0, 32'hFFFF_BEEF, 0, 0, 2));
    vecs.push_back(mk("SB",    32'h0000_3001, 32'h1234_56AB, 1, 3'b000, 32'h0,        3,  0, 32'h0000_3000, 32'hABAB_ABAB, 4'b0010, 1, 32'h0,        0, 0, 5));
    vecs.push_back(mk("LWmis", 32'h0000_4002, 32'h0,        0, 3'b010, 32'h0,        0,  0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1, 0, 1));
    vecs.push_back(mk("SHmis", 32'h0000_4001, 32'h0000_1111, 1, 3'b001, 32'h0,        0,  0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1, 0, 1));
    vecs.push_back(mk("LWto",  32'h0000_5000, 32'h0,        0, 3'b010, 32'h1111_1111, 99, 5, 32'h0000_5000, 32'h0,        4'b0000, 0, 32'h0,        0, 1, 5));
    vecs.push_back(mk("SW",    32'h0000_6004, 32'hDEAD_BEEF, 1, 3'b010, 32'h0,        0,  0, 32'h0000_6004, 32'hDEAD_BEEF, 4'b1111, 1, 32'h0,        0, 0, 2));
    vecs.push_back(mk("SH",    32'h0000_6006, 32'h0000_CAFE, 1, 3'b001, 32'h0,        1,  0, 32'h0000_6004, 32'hCAFE_CAFE, 4'b1100, 1, 32'h0,        0, 0, 3));
    vecs.push_back(mk("LBU",   32'h0000_7001, 32'h0,        0, 3'b100, 32'h1234_80FF, 0,  0, 32'h0000_7000, 32'h0,        4'b0000, 0, 32'h0000_0080, 0, 0, 2));
    vecs.push_back(mk("F3_011",32'h0000_8000, 32'h0,        0, 3'b011, 32'h89AB_CDEF, 0,  0, 32'h0000_8000, 32'h0,        4'b0000, 0, 32'h89AB_CDEF, 0, 0, 2));
    vecs.push_back(mk("LW",    32'h0000_9000, 32'h0,        0, 3'b010, 32'h1357_9BDF, 1,  2, 32'h0000_9000, 32'h0,        4'b0000, 0, 32'h1357_9BDF, 0, 0, 3));

    // Reset state
    #12;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // mem_ready while idle must not start or complete anything
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle ready mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("idle ready resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("idle ready req_ready", {31'd0, req_ready}, 32'd1);
    end
    mem_ready = 1'b0;
    $display("txn idle_mem_ready ignored");

    // Reset in the middle of a BUS phase
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_A000; req_funct3 = 3'b010; req_store = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
    chk("midrst in bus", {31'd0, mem_valid}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("txn midrst addr=0000a000 discarded");
    run_vec(mk("LW0", 32'h0, 32'h0, 0, 3'b010, 32'h0BAD_F00D, 0, 0, 32'h0, 32'h0, 4'b0000, 0,
               32'h0BAD_F00D, 0, 0, 2));

    chk("scoreboard drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the execute/memory boundary of the tiny5 core.
- Consumes the effective address produced by the ALU (ALU_OP_ADD of rs1 + imm) plus store data and access type.
- Performs one word-aligned data-memory transaction per request: byte-lane steering, write-mask generation, load sign/zero extension and misalignment detection.
- Returns the load result or fault to writeback through a valid/ready response.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles to wait for mem_ready_i before a bus-error response; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  async active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  LSU can accept a request
- req_addr_i  in  32  effective address (ALU output)
- req_wdata_i  in  32  store data (rs2), right-aligned
- req_store_i  in  1  1=store, 0=load
- req_funct3_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_valid_o  out  1  bus request
- mem_addr_o  out  32  word address, low two bits always 0
- mem_wdata_o  out  32  lane-shifted store data
- mem_wmask_o  out  4  byte write enables, 0000 for loads
- mem_we_o  out  1  write strobe
- mem_ready_i  in  1  bus completes this cycle
- mem_rdata_i  in  32  read word, valid when mem_ready_i=1
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  writeback accepts response
- resp_rdata_o  out  32  extended load data, 0 for stores
- resp_misaligned_o  out  1  address misaligned for access size
- resp_buserr_o  out  1  bus timeout

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high. Reset forces state IDLE, timeout counter 0 and all outputs 0, except req_ready_o = 1.
- FSM state IDLE:
  - req_ready_o = 1; a request is accepted when req_valid_i & req_ready_o.
  - Accepted request registers the address, size, signedness, store flag and lane-shifted data/mask.
  - Misaligned requests (H with addr[0]=1; W with addr[1:0]!=0) go to RESP with resp_misaligned_o=1, rdata 0, and never assert mem_valid_o.
  - Otherwise go to BUS.
- FSM state BUS:
  - mem_valid_o = 1; addr, wdata, wmask and we are held stable until mem_ready_i.
  - On mem_ready_i: capture the extended load data and go to RESP.
  - The counter increments each BUS cycle without mem_ready_i. Reaching TIMEOUT_CYCLES goes to RESP with resp_buserr_o=1, drops mem_valid_o and returns rdata 0.
- FSM state RESP:
  - resp_valid_o = 1; outputs held stable until resp_ready_i.
  - On resp_ready_i: go to IDLE and clear the counter.
  - req_ready_o = 0 throughout BUS and RESP; there is no request pipelining.
- Latency: accept in cycle N, mem_valid_o in N+1, and resp_valid_o in N+2 if mem_ready_i arrives in N+1 (minimum 2 cycles). A misaligned request responds in N+1.
- Store lanes:
  - B: wdata = {4{wdata[7:0]}}, mask = 0001 << addr[1:0].
  - H: wdata = {2{wdata[15:0]}}, mask = 0011 << addr[1:0].
  - W: wdata passes unchanged, mask = 1111.
  - mem_we_o = 1 only for stores.
- Load extraction: select the byte or halfword from mem_rdata_i at addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Unsupported funct3 values (011, 110, 111) are treated as W.
- If mem_ready_i is asserted outside BUS, it is ignored.
- Reset during BUS or RESP drops mem_valid_o and resp_valid_o immediately and discards the transaction.

Test Plan:
- Load byte: LB addr=0x1003, mem_rdata=0x80FF_1234 with mem_ready on the first BUS cycle -> mem_addr=0x1000, wmask=0000, resp_rdata=0xFFFF_FF80 at accept+2.
- Load halfword unsigned: LHU addr=0x2002, rdata=0xBEEF_0000 -> resp_rdata=0x0000_BEEF. LH at the same address -> 0xFFFF_BEEF.
- Store byte: SB addr=0x3001, wdata=0x1234_56AB -> mem_wdata=0xABAB_ABAB, wmask=0010, we=1. Hold mem_ready low 3 cycles -> address and data stable, response after ready.
- Misaligned access: LW addr=0x4002 -> mem_valid never 1, resp_misaligned=1 at accept+1. SH addr=0x4001 -> same response.
- Timeout and backpressure: TIMEOUT_CYCLES=4, mem_ready held 0 -> resp_buserr=1 after 4 BUS cycles. Then hold resp_ready=0 for 5 cycles -> response held and req_ready=0 throughout.
- Reset mid-operation: assert reset_i during BUS -> all outputs 0 and req_ready=1 asynchronously. A new LW 0x0 afterwards completes normally.
